// File: rtl/fib_seq_ctrl_pkg.sv
// Shared types and constants for the Fibonacci job controller.
package fib_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    EMIT
  } state_t;

  localparam int DATA_BUS_DEF = 32;
  localparam int CNT_W_DEF    = 16;

  localparam int unsigned FIB_F0 = 0;
  localparam int unsigned FIB_F1 = 1;

endpackage

// File: rtl/fib_seq_ctrl_if.sv
// Request, term-stream and status bundle of the Fibonacci job controller.
interface fib_seq_ctrl_if
  import fib_ctrl_pkg::*;
#(
  parameter int DataBus = DATA_BUS_DEF,
  parameter int CntW    = CNT_W_DEF
);
  logic              req_valid_w;
  logic              req_ready_w;
  logic [CntW-1:0]   req_start_w;
  logic [CntW-1:0]   req_count_w;
  logic              abort_w;
  logic              term_valid_w;
  logic              term_ready_w;
  logic [DataBus-1:0] term_data_w;
  logic [CntW:0]     term_idx_w;
  logic              term_last_w;
  logic              busy_w;
  logic              done_w;
  logic              done_ovf_w;
  logic              done_abort_w;

  modport master (
    output req_valid_w, req_start_w, req_count_w, abort_w, term_ready_w,
    input  req_ready_w, term_valid_w, term_data_w, term_idx_w, term_last_w,
    input  busy_w, done_w, done_ovf_w, done_abort_w
  );

  modport slave (
    input  req_valid_w, req_start_w, req_count_w, abort_w, term_ready_w,
    output req_ready_w, term_valid_w, term_data_w, term_idx_w, term_last_w,
    output busy_w, done_w, done_ovf_w, done_abort_w
  );

endinterface

// File: rtl/fib_seq_ctrl_pair_dp.sv
// Fibonacci pair register (a,b)=(F(k),F(k+1)) with load/step controls.
// FIB_SEQ_CTRL_OVF_EN adds a sticky carry flag for b.
module fib_pair_dp
  import fib_ctrl_pkg::*;
#(
  parameter int DataBus = DATA_BUS_DEF
)
(
  input  logic               clk_w,
  input  logic               reset_w,
  input  logic               load,
  input  logic               step,
  output logic [DataBus-1:0] a
`ifdef FIB_SEQ_CTRL_OVF_EN
  ,
  output logic               b_ovf
`endif
);

  logic [DataBus-1:0] b;

`ifdef FIB_SEQ_CTRL_OVF_EN
  // a's flag is b's flag one step late, so only b's is stored and the
  // controller reads it as the overflow status of the next term.
  logic [DataBus:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk_w or posedge reset_w) begin
    if (reset_w) begin
      a     <= DataBus'(FIB_F0);
      b     <= DataBus'(FIB_F1);
      b_ovf <= 1'b0;
    end else if (load) begin
      a     <= DataBus'(FIB_F0);
      b     <= DataBus'(FIB_F1);
      b_ovf <= 1'b0;
    end else if (step) begin
      a     <= b;
      b     <= sum[DataBus-1:0];
      b_ovf <= b_ovf | sum[DataBus];
    end
  end
`else
  always_ff @(posedge clk_w or posedge reset_w) begin
    if (reset_w) begin
      a <= DataBus'(FIB_F0);
      b <= DataBus'(FIB_F1);
    end else if (load) begin
      a <= DataBus'(FIB_F0);
      b <= DataBus'(FIB_F1);
    end else if (step) begin
      a <= b;
      b <= a + b;
    end
  end
`endif

endmodule

// File: rtl/fib_seq_ctrl.sv
// Job controller: accepts (start, count), skips to F(start), streams count terms.
// FIB_SEQ_CTRL_OVF_EN ends a job early instead of emitting an overflowed term.
module fib_seq_ctrl
  import fib_ctrl_pkg::*;
#(
  parameter int DataBus = DATA_BUS_DEF,
  parameter int CntW    = CNT_W_DEF
)
(
  input  logic          clk_w,
  input  logic          reset_w,
  fib_seq_ctrl_if.slave bus
);

  state_t             state, state_nx;
  logic [CntW-1:0]    skip_cnt, remain;
  logic [CntW:0]      idx;
  logic [DataBus-1:0] a;
  logic               load, step, handshake, is_last;
  logic               done_nx, done_abort_nx;
  logic               done_q, done_abort_q;
`ifdef FIB_SEQ_CTRL_OVF_EN
  logic               b_ovf;
  logic               done_ovf_nx, done_ovf_q;
`endif

  fib_pair_dp #(.DataBus(DataBus)) u_dp (
    .clk_w   (clk_w),
    .reset_w (reset_w),
    .load    (load),
    .step    (step),
    .a       (a)
`ifdef FIB_SEQ_CTRL_OVF_EN
    ,
    .b_ovf   (b_ovf)
`endif
  );

  assign handshake = (state == EMIT) & bus.term_ready_w;
  assign is_last   = (remain == CntW'(1));

  always_ff @(posedge clk_w or posedge reset_w) begin
    if (reset_w) state <= IDLE;
    else         state <= state_nx;
  end

  // A final handshake outranks a simultaneous abort; abort outranks overflow.
  always_comb begin
    state_nx      = state;
    load          = 1'b0;
    step          = 1'b0;
    done_nx       = 1'b0;
    done_abort_nx = 1'b0;
`ifdef FIB_SEQ_CTRL_OVF_EN
    done_ovf_nx   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.req_valid_w) begin
          load = 1'b1;
          if (bus.req_count_w == '0)      done_nx  = 1'b1;
          else if (bus.req_start_w != '0) state_nx = SKIP;
          else                            state_nx = EMIT;
        end
      end
      SKIP: begin
        if (bus.abort_w) begin
          state_nx      = IDLE;
          done_nx       = 1'b1;
          done_abort_nx = 1'b1;
        end else begin
          step = 1'b1;
          if (skip_cnt == CntW'(1)) begin
            state_nx = EMIT;
`ifdef FIB_SEQ_CTRL_OVF_EN
            if (b_ovf) begin
              state_nx    = IDLE;
              done_nx     = 1'b1;
              done_ovf_nx = 1'b1;
            end
`endif
          end
        end
      end
      EMIT: begin
        if (handshake && is_last) begin
          step     = 1'b1;
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (bus.abort_w) begin
          state_nx      = IDLE;
          done_nx       = 1'b1;
          done_abort_nx = 1'b1;
        end else if (handshake) begin
          step = 1'b1;
`ifdef FIB_SEQ_CTRL_OVF_EN
          if (b_ovf) begin
            state_nx    = IDLE;
            done_nx     = 1'b1;
            done_ovf_nx = 1'b1;
          end
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_w or posedge reset_w) begin
    if (reset_w) begin
      skip_cnt <= '0;
      remain   <= '0;
      idx      <= '0;
    end else if (load) begin
      skip_cnt <= bus.req_start_w;
      remain   <= bus.req_count_w;
      idx      <= {1'b0, bus.req_start_w};
    end else begin
      if (state == SKIP && step) skip_cnt <= skip_cnt - CntW'(1);
      if (handshake) begin
        remain <= remain - CntW'(1);
        idx    <= idx + (CntW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_w or posedge reset_w) begin
    if (reset_w) begin
      done_q       <= 1'b0;
      done_abort_q <= 1'b0;
`ifdef FIB_SEQ_CTRL_OVF_EN
      done_ovf_q   <= 1'b0;
`endif
    end else begin
      done_q       <= done_nx;
      done_abort_q <= done_abort_nx;
`ifdef FIB_SEQ_CTRL_OVF_EN
      done_ovf_q   <= done_ovf_nx;
`endif
    end
  end

  assign bus.req_ready_w  = (state == IDLE);
  assign bus.busy_w       = (state != IDLE);
  assign bus.term_valid_w = (state == EMIT);
  assign bus.term_data_w  = (state == EMIT) ? a : '0;
  assign bus.term_idx_w   = (state == EMIT) ? idx : '0;
  assign bus.term_last_w  = (state == EMIT) & is_last;
  assign bus.done_w       = done_q;
  assign bus.done_abort_w = done_abort_q;
`ifdef FIB_SEQ_CTRL_OVF_EN
  assign bus.done_ovf_w   = done_ovf_q;
`else
  assign bus.done_ovf_w   = 1'b0;
`endif

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Table-driven bench for fib_seq_ctrl with a term scoreboard; a 32-bit and an 8-bit instance.
module tb_fib_seq_ctrl;

`ifdef FIB_SEQ_CTRL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    bit     use8;
    int     start;
    int     count;
    bit     stall;
    int     abort_on;
    int     exp_terms;
    int     exp_kind;
    int     exp_done_lat;
    int     exp_first_lat;
    longint exp_last;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [63:0] idx;
    logic        last;
  } term_t;

  typedef struct {
    logic        rready, tv, tlast, busy, done, dovf, dabort;
    logic [63:0] data;
    logic [63:0] idx;
  } obs_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    n_vec = 0;
  int    n_err = 0;
  term_t exp_q[$];
  vec_t  vecs[9];

  always #5 clk = ~clk;

  fib_seq_ctrl_if #(.DataBus(32), .CntW(16)) bus32 ();
  fib_seq_ctrl_if #(.DataBus(8),  .CntW(16)) bus8 ();

  fib_seq_ctrl #(.DataBus(32), .CntW(16)) dut32 (.clk_w(clk), .reset_w(rst), .bus(bus32.slave));
  fib_seq_ctrl #(.DataBus(8),  .CntW(16)) dut8  (.clk_w(clk), .reset_w(rst), .bus(bus8.slave));

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input longint act, input longint exp);
    n_vec++;
    n_err++;
    $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic obs_t sample(input bit use8);
    obs_t o;
    if (use8) begin
      o.rready = bus8.req_ready_w;  o.tv   = bus8.term_valid_w; o.tlast  = bus8.term_last_w;
      o.busy   = bus8.busy_w;       o.done = bus8.done_w;       o.dovf   = bus8.done_ovf_w;
      o.dabort = bus8.done_abort_w;
      o.data   = 64'(bus8.term_data_w);
      o.idx    = 64'(bus8.term_idx_w);
    end else begin
      o.rready = bus32.req_ready_w; o.tv   = bus32.term_valid_w; o.tlast  = bus32.term_last_w;
      o.busy   = bus32.busy_w;      o.done = bus32.done_w;       o.dovf   = bus32.done_ovf_w;
      o.dabort = bus32.done_abort_w;
      o.data   = 64'(bus32.term_data_w);
      o.idx    = 64'(bus32.term_idx_w);
    end
    return o;
  endfunction

  function automatic logic [6:0] flags(input obs_t o);
    return {o.rready, o.tv, o.tlast, o.busy, o.done, o.dovf, o.dabort};
  endfunction

  task automatic drive(input bit use8, input logic valid, input int start, input int count,
                       input logic abort, input logic ready);
    if (use8) begin
      bus8.req_valid_w = valid;  bus8.req_start_w = 16'(start); bus8.req_count_w = 16'(count);
      bus8.abort_w     = abort;  bus8.term_ready_w = ready;
    end else begin
      bus32.req_valid_w = valid; bus32.req_start_w = 16'(start); bus32.req_count_w = 16'(count);
      bus32.abort_w     = abort; bus32.term_ready_w = ready;
    end
  endtask

  // Reference sequence computed in 64-bit arithmetic, then reduced to the port width.
  task automatic build_expect(input bit use8, input int start, input int count);
    longint fa, fb, t, lim;
    term_t  e;
    lim = use8 ? 64'd256 : 64'd4294967296;
    fa  = 0;
    fb  = 1;
    for (int k = 0; k < start; k++) begin
      t = fa + fb; fa = fb; fb = t;
    end
    for (int k = start; k < start + count; k++) begin
      if (OVF_EN && fa >= lim) break;
      e.data = 64'(fa % lim);
      e.idx  = 64'(k);
      e.last = (k == start + count - 1);
      exp_q.push_back(e);
      t = fa + fb; fa = fb; fb = t;
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag, output int n_terms, output int kind,
                                output int done_lat, output int first_lat, output longint last_data);
    obs_t o;
    logic rdy, ab;
    bit   got_done;
    int   c;
    build_expect(v.use8, v.start, v.count);
    n_terms = 0; kind = -1; done_lat = -1; first_lat = -1; last_data = -1; got_done = 0;
    o = sample(v.use8);
    check({tag, "_idle_ready"}, 64'(o.rready), 64'd1);
    drive(v.use8, 1'b1, v.start, v.count, 1'b0, 1'b1);
    tick();
    drive(v.use8, 1'b0, 0, 0, 1'b0, 1'b1);
    c = 1;
    while (!got_done && c <= 300) begin
      o = sample(v.use8);
      if (o.done) begin
        got_done = 1;
        done_lat = c;
        kind     = o.dabort ? 2 : (o.dovf ? 1 : 0);
        check({tag, "_done_ready"}, 64'(o.rready), 64'd1);
        check({tag, "_done_flag_excl"}, 64'(o.dovf & o.dabort), 64'd0);
      end else begin
        rdy = v.stall ? (c % 2 == 0) : 1'b1;
        ab  = 1'b0;
        if (o.tv) begin
          if (first_lat < 0) first_lat = c;
          if (n_terms == v.abort_on) begin
            ab = 1'b1;
            if (n_terms != v.count - 1) rdy = 1'b0;
          end
          if (exp_q.size() == 0) begin
            note_fail({tag, "_unexpected_term"}, longint'(o.data), -1);
          end else begin
            check({tag, "_data"}, o.data, exp_q[0].data);
            check({tag, "_idx"},  o.idx,  exp_q[0].idx);
            check({tag, "_last"}, 64'(o.tlast), 64'(exp_q[0].last));
            if (rdy) begin
              void'(exp_q.pop_front());
              n_terms++;
              last_data = longint'(o.data);
            end
          end
        end
        drive(v.use8, 1'b0, 0, 0, ab, rdy);
        tick();
        c++;
      end
    end
    drive(v.use8, 1'b0, 0, 0, 1'b0, 1'b1);
    if (!got_done) note_fail({tag, "_done_timeout"}, c, 0);
    tick();
    o = sample(v.use8);
    check({tag, "_done_width"}, 64'(o.done), 64'd0);
    if (kind != 2) check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_output(input vec_t v, input string tag);
    int     n_terms, kind, done_lat, first_lat;
    longint last_data;
    apply_stimulus(v, tag, n_terms, kind, done_lat, first_lat, last_data);
    check({tag, "_n_terms"},   64'(n_terms),   64'(v.exp_terms));
    check({tag, "_done_kind"}, 64'(kind),      64'(v.exp_kind));
    check({tag, "_done_lat"},  64'(done_lat),  64'(v.exp_done_lat));
    check({tag, "_first_lat"}, 64'(first_lat), 64'(v.exp_first_lat));
    check({tag, "_last_data"}, 64'(last_data), 64'(v.exp_last));
  endtask

  initial begin
    obs_t o;
    vec_t rv;
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    o = sample(1'b0);
    check("reset_flags32", 64'(flags(o)), 64'h40);
    check("reset_data32",  o.data, 64'd0);
    check("reset_idx32",   o.idx,  64'd0);
    o = sample(1'b1);
    check("reset_flags8",  64'(flags(o)), 64'h40);
    rst = 1'b0;
    tick();

    // {use8, S, N, stall, abort_on, terms, kind, done_lat, first_lat, last_data}
    vecs[0] = '{0, 0,  8, 0, -1, 8, 0, 9,  1,  13};
    vecs[1] = '{0, 10, 3, 1, -1, 3, 0, 17, 11, 144};
    vecs[2] = '{0, 5,  0, 0, -1, 0, 0, 1,  -1, -1};
`ifdef FIB_SEQ_CTRL_OVF_EN
    vecs[3] = '{1, 10, 6, 0, -1, 4, 1, 15, 11, 233};
    vecs[8] = '{1, 14, 2, 0, -1, 0, 1, 15, -1, -1};
`else
    vecs[3] = '{1, 10, 6, 0, -1, 6, 0, 17, 11, 98};
    vecs[8] = '{1, 14, 2, 0, -1, 2, 0, 17, 15, 98};
`endif
    vecs[4] = '{0, 0,  8, 0, 1,  1, 2, 3,  1,  0};
    vecs[5] = '{0, 0,  3, 0, 2,  3, 0, 4,  1,  1};
    vecs[6] = '{0, 1,  1, 0, -1, 1, 0, 3,  2,  1};
    vecs[7] = '{0, 47, 1, 0, -1, 1, 0, 49, 48, 64'd2971215073};

    foreach (vecs[i]) check_output(vecs[i], $sformatf("v%0d", i));

    // Back-to-back: second request issued in the cycle done is high.
    drive(1'b0, 1'b1, 0, 1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    o = sample(1'b0);
    check("b2b_first_valid", 64'(o.tv), 64'd1);
    check("b2b_first_last",  64'(o.tlast), 64'd1);
    tick();
    o = sample(1'b0);
    check("b2b_done", 64'(o.done), 64'd1);
    drive(1'b0, 1'b1, 3, 1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    o = sample(1'b0);
    check("b2b_busy", 64'(o.busy), 64'd1);
    check("b2b_skip_no_valid", 64'(o.tv), 64'd0);
    repeat (3) tick();
    o = sample(1'b0);
    check("b2b_second_valid", 64'(o.tv), 64'd1);
    check("b2b_second_data",  o.data, 64'd2);
    check("b2b_second_idx",   o.idx,  64'd3);
    tick();
    o = sample(1'b0);
    check("b2b_second_done", 64'(o.done), 64'd1);
    tick();

    // Abort in IDLE together with a request: the request is taken.
    drive(1'b0, 1'b1, 0, 1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    o = sample(1'b0);
    check("idle_abort_busy", 64'(o.busy), 64'd1);
    check("idle_abort_data", o.data, 64'd0);
    tick();
    o = sample(1'b0);
    check("idle_abort_done",  64'(o.done), 64'd1);
    check("idle_abort_flag",  64'(o.dabort), 64'd0);
    tick();

    // Reset in the middle of a stalled EMIT, then a fresh job.
    drive(1'b0, 1'b1, 0, 8, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    o = sample(1'b0);
    check("mid_emit_valid", 64'(o.tv), 64'd1);
    #2 rst = 1'b1;
    #1;
    o = sample(1'b0);
    check("mid_reset_flags", 64'(flags(o)), 64'h40);
    check("mid_reset_data",  o.data, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    tick();
    rv = '{0, 0, 2, 0, -1, 2, 0, 3, 1, 1};
    check_output(rv, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fib_seq_ctrl.md
# fib_seq_ctrl

Job controller for the Fibonacci datapath. Accepts a request (start index S, term count N) over a valid/ready handshake, advances a private Fibonacci pair register to F(S), then streams F(S)…F(S+N−1) on a backpressured output port and pulses a completion status. It sits between a host/CSR requester and downstream consumers that need a bounded, indexed slice of the sequence rather than a free-running one.

## Interface
- `DataBus`, 32, width of term values
- `CntW`, 16, width of start index and count fields
- `clk_w` in 1: single clock, rising edge
- `reset_w` in 1: asynchronous, active-high reset
- `req_valid_w` in 1: request present
- `req_ready_w` out 1: controller idle and able to accept
- `req_start_w` in CntW: first term index S (F(0)=0, F(1)=1)
- `req_count_w` in CntW: number of terms N
- `abort_w` in 1: synchronous job cancel
- `term_valid_w` out 1: term presented
- `term_ready_w` in 1: consumer accepts term
- `term_data_w` out DataBus: F(idx)
- `term_idx_w` out CntW+1: index of presented term
- `term_last_w` out 1: final term of job
- `busy_w` out 1: job in progress (state ≠ IDLE)
- `done_w` out 1: one-cycle completion pulse
- `done_ovf_w` out 1: qualifies `done_w`; job ended on overflow
- `done_abort_w` out 1: qualifies `done_w`; job ended by abort

## Operation
- States: IDLE, SKIP, EMIT.
- Datapath pair (a,b) = (F(k),F(k+1)); step: a←b, b←a+b (DataBus-bit, carry captured); loaded to (0,1) on accept.
- IDLE: `req_ready_w`=1. Accept on `req_valid_w & req_ready_w`; latch S, N. Next: N=0 → IDLE with `done_w`; S>0 → SKIP; else EMIT.
- SKIP: one step per cycle, S cycles total, then EMIT.
- EMIT: `term_valid_w`=1, data=a, idx=S+emitted, `term_last_w`=(remaining==1). On handshake: step; if last → IDLE with `done_w`.
- Outputs stable while `term_valid_w & ~term_ready_w`; valid never drops without a handshake except on abort/reset.
- Abort in SKIP/EMIT → IDLE next cycle, `done_w`+`done_abort_w`. Abort in the same cycle as the final handshake: transfer completes, normal done, abort ignored. Abort in IDLE ignored; a request in that cycle is accepted.
- Reset (any time, incl. mid-job): IDLE, pair=(0,1), counters 0, job discarded, no done pulse.

## Timing
- Reset values: `req_ready_w`=1, all other outputs 0.
- Accept at cycle T: first `term_valid_w` at T+1+S; with `term_ready_w` held high, N terms on consecutive cycles; `done_w` at cycle after last handshake, coincident with `req_ready_w`=1.
- N=0: `done_w` at T+1 regardless of S; no terms.
- `done_*` are registered, high exactly one cycle; `done_ovf_w`/`done_abort_w` never both high.
- Back-to-back: a new request is acceptable in the same cycle `done_w` is high.

## Configuration
- `FIB_SEQ_CTRL_OVF_EN` defined: per-register sticky overflow bits track the pair (b_ovf |= carry; a_ovf←b_ovf on step). Whenever the term about to be presented (end of SKIP or after an EMIT step) has a_ovf=1, controller goes to IDLE instead, with `done_w`+`done_ovf_w`; no overflowed value ever appears on `term_data_w`; `term_last_w` is not asserted for such a job.
- Undefined: values wrap modulo 2^DataBus, all N terms emitted, `done_ovf_w` tied 0, no overflow logic.

## Structure
- Package `fib_ctrl_pkg`: state enum (IDLE, SKIP, EMIT), default parameter constants, F(0)/F(1) seed constants.
- Sub-module `fib_pair_dp`: pair registers, adder, carry/overflow bits, load/step controls. Controller holds FSM, counters, handshake.

## Test plan
- DataBus=32, S=0, N=8, ready=1 → terms 0,1,1,2,3,5,8,13 on consecutive cycles, idx 0..7, last on 13, `done_w` next cycle.
- S=10, N=3, ready toggling 1/0 → first valid at T+11; 55,89,144 each held stable during stalls; done after 144.
- N=0, S=5 → `done_w` at T+1, no `term_valid_w`.
- DataBus=8, S=10, N=6: with macro → 55,89,144,233, then `done_ovf_w`, no last; without → 55,89,144,233,121,98, last on 98.
- Abort on 2nd term of S=0, N=8 → `done_abort_w` next cycle; abort coinciding with final handshake → normal done.
- `reset_w` asserted mid-EMIT → outputs to reset values immediately; next request S=0,N=2 → 0,1.
